// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: datapath defaults, RV32 major opcodes
// and the fetch FSM state encoding.
package rv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        S_BOOT,
        S_FETCH
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering {pc, instr} pairs between memory and decode.
// Clear wins over push and pop; push into a full FIFO is allowed when a pop frees a slot.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC ownership, credit-limited in-order fetch, response
// buffering and redirect handling with discard of stale in-flight responses.
module instr_fetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0],
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0]   outst_q, outst_d, discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic            req_fire, rsp_keep;
    logic [XLEN+31:0] fifo_rdata;

    fetch_fifo #(
        .W     (XLEN + 32),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect_valid),
        .push_i  (rsp_keep),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH;
        endcase
    end

    // Every buffered or in-flight word holds a FIFO slot, so responses never stall.
    assign credit_used    = {1'b0, outst_q} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q == S_FETCH) && !redirect_valid &&
                            (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign redir_pc       = redirect_pc & ~XLEN'(3);

    assign id_valid  = !fifo_empty;
    assign fifo_pop  = id_valid && id_ready;
    assign id_pc     = id_valid ? fifo_rdata[XLEN+31:32] : '0;
    assign id_instr  = id_valid ? fifo_rdata[31:0] : '0;
    assign id_opcode = id_instr[6:0];

    always_comb begin
        outst_d = outst_q;
        if (req_fire && !imem_rsp_valid)      outst_d = outst_q + ONE_C;
        else if (!req_fire && imem_rsp_valid) outst_d = outst_q - ONE_C;
    end

    // On redirect every in-flight word is stale; discard already counts a subset of
    // outstanding, so the new total is simply what remains in flight.
    always_comb begin
        discard_d = discard_q;
        if (redirect_valid)
            discard_d = imem_rsp_valid ? outst_q - ONE_C : outst_q;
        else if (imem_rsp_valid && discard_q != '0)
            discard_d = discard_q - ONE_C;
    end

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        if (redirect_valid) begin
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
        end else begin
            if (req_fire) pc_d     = pc_q + PC_STEP;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outst_q != '0));
    a_rsp_room: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: latency-configurable memory, epoch-based reference
// model checked every cycle, and directed scenarios with hand-computed expectations.
module tb_instr_fetch_stage;
    import rv_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_pc, id_instr;
    logic [6:0]  id_opcode;

    instr_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instr(id_instr), .id_opcode(id_opcode)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mq[$];       // accepted, not yet answered memory requests
    ent_t        mf[$];       // words decode should currently see, head first
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_pc = RESET_PC;
    int          epoch = 0, cyc = 0, since_rst = -1, first_idv = -1, lat = 1;
    int          n_chk = 0, n_err = 0;
    bit          rst_prev = 1'b0, m_exp_rv;
    mreq_t       r;
    ent_t        e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OP_R;
            3'd1:    op = OP_I;
            3'd2:    op = OP_LOAD;
            3'd3:    op = OP_STORE;
            3'd4:    op = OP_BRANCH;
            default: op = 7'h6F;
        endcase
        return {a[31:7] ^ 25'h0ABCDEF, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory + model + per-cycle compare; runs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst || mq.size() == 0 || mq[0].due > cyc) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end
        #1;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
                chk("rst_id_valid",  32'(id_valid), 32'd0);
                chk("rst_id_pc",     id_pc, 32'd0);
                chk("rst_id_instr",  id_instr, 32'd0);
                chk("rst_id_opcode", 32'(id_opcode), 32'd0);
            end
            mq.delete();
            mf.delete();
            m_pc      = RESET_PC;
            since_rst = -1;
            first_idv = -1;
        end else begin
            since_rst++;
            m_exp_rv = (since_rst >= 1) && !redirect_valid && (mq.size() + mf.size() < DEPTH);
            chk("req_valid", 32'(imem_req_valid), 32'(m_exp_rv));
            if (m_exp_rv) chk("req_addr", imem_req_addr, m_pc);
            if (mf.size() > 0) begin
                chk("id_valid",  32'(id_valid), 32'd1);
                chk("id_pc",     id_pc, mf[0].pc);
                chk("id_instr",  id_instr, mf[0].instr);
                chk("id_opcode", 32'(id_opcode), 32'(mf[0].instr[6:0]));
            end else begin
                chk("id_valid_empty",  32'(id_valid), 32'd0);
                chk("id_pc_empty",     id_pc, 32'd0);
                chk("id_instr_empty",  id_instr, 32'd0);
                chk("id_opcode_empty", 32'(id_opcode), 32'd0);
            end
            if (id_valid && first_idv < 0) first_idv = since_rst;
            if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
            if (id_valid && id_ready && !redirect_valid) pop_log.push_back(id_pc);

            if (redirect_valid) begin
                if (imem_rsp_valid) void'(mq.pop_front());
                mf.delete();
                epoch++;
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (mf.size() > 0 && id_ready) void'(mf.pop_front());
                if (imem_rsp_valid) begin
                    r = mq.pop_front();
                    if (r.ep == epoch) begin
                        e.pc    = r.addr;
                        e.instr = mem_word(r.addr);
                        mf.push_back(e);
                    end
                end
                if (m_exp_rv && imem_req_ready) begin
                    r.addr = m_pc;
                    r.due  = cyc + lat;
                    r.ep   = epoch;
                    mq.push_back(r);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        rst_prev = rst;
        cyc++;
    end

    task automatic cyc_(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b1;
        cyc_(n);
        rst = 1'b0;
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        acc_log.delete();
        pop_log.delete();
        cyc_(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        // 1: reset release, 1-cycle memory, streaming decode
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        hold_reset(3);
        cyc_(2);
        chk("t1_idv_c2", 32'(id_valid), 32'd0);
        cyc_(1);
        chk("t1_idv_c3", 32'(id_valid), 32'd1);
        chk("t1_pc_c3", id_pc, 32'h0);
        chk("t1_op_c3", 32'(id_opcode), 32'h33);
        cyc_(9);
        chk("t1_first_idv", 32'(first_idv), 32'd3);
        chk("t1_acc0", acc_at(0), 32'h0);
        chk("t1_acc1", acc_at(1), 32'h4);
        chk("t1_acc2", acc_at(2), 32'h8);

        // 2: decode stalled, credit caps requests at DEPTH
        id_ready = 1'b0;
        hold_reset(2);
        cyc_(10);
        chk("t2_acc_cnt", 32'(acc_log.size()), 32'd2);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        id_ready = 1'b1;
        cyc_(10);
        chk("t2_acc2", acc_at(2), 32'h8);
        chk("t2_pop0", pop_at(0), 32'h0);
        chk("t2_pop1", pop_at(1), 32'h4);
        chk("t2_pop2", pop_at(2), 32'h8);

        // 3: 3-cycle memory, redirect with two fetches in flight
        lat = 3;
        hold_reset(2);
        cyc_(3);
        redirect_to(32'h103);
        cyc_(15);
        chk("t3_acc0", acc_at(0), 32'h100);
        chk("t3_acc1", acc_at(1), 32'h104);
        chk("t3_pop0", pop_at(0), 32'h100);

        // 4: redirect coincides with a response and a decode pop
        lat = 1;
        hold_reset(2);
        cyc_(3);
        chk("t4_idv_pre", 32'(id_valid), 32'd1);
        redirect_to(32'h200);
        #1;
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        chk("t4_idv_post", 32'(id_valid), 32'd0);
        cyc_(6);
        chk("t4_pop0", pop_at(0), 32'h200);

        // 5: random memory/decode backpressure with occasional redirects
        lat = 2;
        hold_reset(2);
        for (int i = 0; i < 200; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom;
            cyc_(1);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        cyc_(4);
        chk("t5_progress", 32'(pop_log.size() > 20), 32'd1);

        // 6: reset mid-stream with two fetches outstanding
        lat = 3;
        hold_reset(2);
        cyc_(3);
        rst = 1'b1;
        cyc_(2);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_id_valid", 32'(id_valid), 32'd0);
        chk("t6_id_pc", id_pc, 32'd0);
        rst = 1'b0;
        acc_log.delete();
        pop_log.delete();
        cyc_(8);
        chk("t6_acc0", acc_at(0), RESET_PC);
        chk("t6_first_idv", 32'(first_idv), 32'd5);
        chk("t6_pop0", pop_at(0), RESET_PC);

        // 7: PC wraps past the top of the address space
        lat = 1;
        hold_reset(2);
        cyc_(2);
        redirect_to(32'hFFFF_FFF9);
        cyc_(10);
        chk("t7_acc0", acc_at(0), 32'hFFFF_FFF8);
        chk("t7_acc1", acc_at(1), 32'hFFFF_FFFC);
        chk("t7_acc2", acc_at(2), 32'h0);
        chk("t7_pop2", pop_at(2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
